// File: rtl/iir_pkg.sv
// ---------------------------------------------------------------------------
// iir_pkg
//   Shared fixed-point formats and conversion helpers for the IIR datapath.
//   Contents:
//     - width / fraction localparams for the FIR-sum input and the bus output
//     - typedefs sfix22_En14_t (input) and sfix16_En10_t (output)
//     - round_half_up() : add half an output LSB, arithmetic shift down
//     - saturate()      : clamp the rounded value into the output range
//     - round_sat()     : both steps in one call, for the feedback path
// ---------------------------------------------------------------------------
package iir_pkg;

  localparam int IN_W     = 22;
  localparam int IN_FRAC  = 14;
  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 10;

  // Fraction bits dropped going from input to output format (must be >= 1).
  localparam int SHIFT = IN_FRAC - OUT_FRAC;

  // One guard bit so that din + half-LSB cannot wrap.
  localparam int RND_W = IN_W + 1;

  localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  typedef logic signed [IN_W-1:0]  sfix22_En14_t;
  typedef logic signed [OUT_W-1:0] sfix16_En10_t;
  typedef logic signed [RND_W-1:0] rnd_t;

  // Saturated result plus a marker telling whether clamping happened.
  typedef struct packed {
    logic         sat;
    sfix16_En10_t data;
  } sat_res_t;

  // Round half up (ties toward +inf): bias by half an output LSB, then
  // arithmetic shift. The result keeps the guard bit so it can exceed the
  // output range; saturate() deals with that.
  function automatic rnd_t round_half_up(input sfix22_En14_t x);
    rnd_t sum;
    sum = rnd_t'(x) + rnd_t'(1 <<< (SHIFT - 1));
    return sum >>> SHIFT;
  endfunction

  function automatic sat_res_t saturate(input rnd_t r);
    sat_res_t res;
    if (r > rnd_t'(OUT_MAX)) begin
      res.sat  = 1'b1;
      res.data = sfix16_En10_t'(OUT_MAX);
    end else if (r < rnd_t'(OUT_MIN)) begin
      res.sat  = 1'b1;
      res.data = sfix16_En10_t'(OUT_MIN);
    end else begin
      res.sat  = 1'b0;
      res.data = sfix16_En10_t'(r);
    end
    return res;
  endfunction

  // Single-cycle form of the two pipeline steps above.
  function automatic sat_res_t round_sat(input sfix22_En14_t x);
    return saturate(round_half_up(x));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO. The head entry is presented
//   on rd_data whenever rd_valid is high; rd_en pops it.
//   A write that finds the FIFO full is accepted only if a pop happens in
//   the same cycle; otherwise it is discarded and wr_drop pulses.
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     wr_en, wr_data  write request and data
//     wr_drop         write discarded this cycle (full, no pop)
//     rd_en           consumer ready; pops when rd_valid
//     rd_data         head entry (0 while empty)
//     rd_valid        FIFO not empty
//     level           number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_drop,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Explicit wrap keeps the pointers correct even if DEPTH is not a
  // power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = rd_en && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign push     = wr_en && (!full || pop);
  assign wr_drop  = wr_en && full && !pop;
  assign rd_valid = !empty;
  // Gate the head so the output reads 0 after reset and while empty.
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/iir_output_stage.sv
// ---------------------------------------------------------------------------
// iir_output_stage
//   Output end of the IIR datapath. Takes the FIR-section sum every valid
//   cycle, keeps one of every DECIM valid samples, rounds (half up) and
//   saturates it from sfix22_En14 to sfix16_En10 over two register stages,
//   and queues the result in a FWFT FIFO read over valid/ready.
//   The FIR section cannot stall, so nothing is pushed back upstream: a
//   result arriving at a full FIFO is lost and drop_flag records it.
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     in_valid     din valid this cycle
//     din          FIR sum, sfix22_En14
//     flags_clr    clears sat_flag / drop_flag (a same-cycle set wins)
//     out_data     FIFO head, sfix16_En10
//     out_valid    out_data holds a valid entry
//     out_ready    consumer accepts when out_valid && out_ready
//     fifo_level   entries held
//     sat_flag     sticky: a kept sample was clamped
//     drop_flag    sticky: a result was lost to a full FIFO
//   Latency: kept sample in cycle 0 -> out_valid in cycle 3 (FIFO empty).
// ---------------------------------------------------------------------------
module iir_output_stage
  import iir_pkg::*;
#(
  parameter int DECIM      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [IN_W-1:0]                 din,
  input  logic                            flags_clr,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            sat_flag,
  output logic                            drop_flag
);

  localparam int STAGES = 2;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // ---------------- decimation ----------------
  logic [DCNT_W-1:0] dcnt;
  logic              keep;

  // Phase 0 is the kept one, so the first valid after reset goes through.
  assign keep = in_valid && (dcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt <= '0;
    end else if (in_valid) begin
      dcnt <= (dcnt == DCNT_W'(DECIM - 1)) ? '0 : dcnt + 1'b1;
    end
  end

  // ---------------- S1 round / S2 saturate ----------------
  // vld_pipe[1] qualifies S1, vld_pipe[STAGES] qualifies S2 (FIFO write).
  logic [STAGES:1] vld_pipe;
  rnd_t            s1_r;
  sat_res_t        s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_r     <= '0;
      s2       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], keep};
      if (keep)        s1_r <= round_half_up(sfix22_En14_t'(din));
      if (vld_pipe[1]) s2   <= saturate(s1_r);
    end
  end

  // ---------------- output FIFO ----------------
  logic wr_drop;

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (vld_pipe[STAGES]),
    .wr_data  (s2.data),
    .wr_drop  (wr_drop),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .level    (fifo_level)
  );

  // ---------------- sticky flags ----------------
  // Saturation is flagged at the FIFO-write edge whether or not the
  // write itself is kept.
  logic sat_set;
  assign sat_set = vld_pipe[STAGES] && s2.sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (sat_set)        sat_flag <= 1'b1;
      else if (flags_clr) sat_flag <= 1'b0;
      if (wr_drop)        drop_flag <= 1'b1;
      else if (flags_clr) drop_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iir_output_stage.sv
// ---------------------------------------------------------------------------
// tb_iir_output_stage
//   Drives iir_output_stage with directed scenarios and a randomized run.
//   A reference model (plain integer arithmetic and queues) predicts the
//   FIFO contents, level and flags; one process compares it with the DUT
//   on every falling edge. Directed scenarios also pin literal values.
// ---------------------------------------------------------------------------
module tb_iir_output_stage;
  import iir_pkg::*;

  localparam int DECIM = 3;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   din = '0;
  logic              flags_clr = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        fifo_level;
  logic              sat_flag;
  logic              drop_flag;

  always #5 clk = ~clk;

  iir_output_stage #(.DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .din        (din),
    .flags_clr  (flags_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .drop_flag  (drop_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int val;
    bit sat;
    int due;   // model cycle whose closing edge writes it into the FIFO
  } pend_t;

  pend_t pend[$];
  int    mfifo[$];
  int    got_q[$];
  bit    m_sat, m_drop, m_ok = 0;
  int    m_dcnt, m_cyc = 0;
  bit    m_pop, m_sat_set, m_drop_set;
  int    m_q;
  bit    m_s;

  // Output value from the arithmetic rule: floor((x + half) / 2^SHIFT),
  // clamped to the 16-bit signed range.
  function automatic void ref_conv(input int x, output int q, output bit s);
    int r;
    int step;
    step = 1 << SHIFT;
    r = x + step / 2;
    q = (r >= 0) ? r / step : -((-r + step - 1) / step);
    s = 0;
    if (q > OUT_MAX) begin q = OUT_MAX; s = 1; end
    else if (q < OUT_MIN) begin q = OUT_MIN; s = 1; end
  endfunction

  // Compare, then advance the model across the coming rising edge using
  // the inputs that are stable now.
  always @(negedge clk) begin
    if (m_ok) begin
      check("out_valid",  out_valid,  mfifo.size() > 0);
      check("fifo_level", fifo_level, mfifo.size());
      check("sat_flag",   sat_flag,   m_sat);
      check("drop_flag",  drop_flag,  m_drop);
      if (mfifo.size() > 0) check("out_data", $signed(out_data), mfifo[0]);
      if (out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
    end
    if (reset) begin
      pend.delete(); mfifo.delete();
      m_sat = 0; m_drop = 0; m_dcnt = 0; m_ok = 1;
    end else if (m_ok) begin
      m_sat_set = 0; m_drop_set = 0;
      m_pop = (mfifo.size() > 0) && out_ready;
      if (m_pop) void'(mfifo.pop_front());
      if (pend.size() > 0 && pend[0].due == m_cyc) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(pend[0].val);
        else m_drop_set = 1;
        m_sat_set = pend[0].sat;
        void'(pend.pop_front());
      end
      if (in_valid) begin
        if (m_dcnt == 0) begin
          ref_conv(int'($signed(din)), m_q, m_s);
          pend.push_back('{m_q, m_s, m_cyc + 2});
        end
        m_dcnt = (m_dcnt + 1) % DECIM;
      end
      m_sat  = m_sat_set  ? 1'b1 : (flags_clr ? 1'b0 : m_sat);
      m_drop = m_drop_set ? 1'b1 : (flags_clr ? 1'b0 : m_drop);
    end
    m_cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit iv, input int d, input bit rdy, input bit clr);
    in_valid  = iv;
    din       = IN_W'(d);
    out_ready = rdy;
    flags_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // One kept sample followed by DECIM-1 valid samples that must be discarded.
  task automatic kept(input int d, input bit rdy);
    cyc(1, d, rdy, 0);
    repeat (DECIM - 1) cyc(1, 12345, rdy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic check_got(input string name, input int exp[$]);
    check({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got_q.size()) ? got_q[i] : -999999, exp[i]);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int d;
    bit iv, rdy, clr;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_level",     fifo_level, 0);
    check("rst_out_data",  $signed(out_data), 0);
    check("rst_sat",       sat_flag, 0);
    check("rst_drop",      drop_flag, 0);

    // 1.0 through the pipe: out_valid in cycle 3.
    cyc(1, 16384, 0, 0);
    check("lat_c1_valid", out_valid, 0);
    cyc(0, 0, 0, 0);
    check("lat_c2_valid", out_valid, 0);
    cyc(0, 0, 0, 0);
    check("lat_c3_valid", out_valid, 1);
    check("lat_c3_data",  $signed(out_data), 1024);
    check("lat_c3_sat",   sat_flag, 0);
    cyc(0, 0, 1, 0);
    check("lat_popped",   out_valid, 0);

    // Rounding ties and near-ties.
    do_reset();
    kept(24, 1); kept(-24, 1); kept(23, 1); kept(-25, 1);
    repeat (5) cyc(0, 0, 1, 0);
    check_got("round", '{2, -1, 1, -2});

    // Saturation both ways, then clear.
    do_reset();
    kept(2097151, 1); kept(-2097152, 1);
    repeat (5) cyc(0, 0, 1, 0);
    check_got("sat", '{32767, -32768});
    check("sat_flag_set", sat_flag, 1);
    cyc(0, 0, 1, 1);
    check("sat_flag_clr", sat_flag, 0);

    // Decimation ramp.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 16 * i, 1, 0);
    repeat (5) cyc(0, 0, 1, 0);
    check_got("decim", '{0, 3, 6});

    // Overflow: six results into a four-entry FIFO.
    do_reset();
    for (int k = 1; k <= 6; k++) kept(16 * k, 0);
    repeat (3) cyc(0, 0, 0, 0);
    check("ovf_level", fifo_level, 4);
    check("ovf_drop",  drop_flag, 1);
    repeat (6) cyc(0, 0, 1, 0);
    check_got("ovf", '{1, 2, 3, 4});

    // Reset with entries stored and the pipeline busy.
    do_reset();
    kept(2097151, 0); kept(32, 0); kept(48, 0);
    cyc(1, 64, 0, 0);
    cyc(1, 80, 0, 0);
    check("pre_rst_level", fifo_level, 3);
    check("pre_rst_sat",   sat_flag, 1);
    reset = 1'b1;
    cyc(1, 96, 0, 0);
    reset = 1'b0;
    got_q.delete();
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat",   sat_flag, 0);
    check("mid_rst_drop",  drop_flag, 0);
    cyc(1, 160, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    check_got("post_rst", '{10});

    // Randomized run; the compare process checks every cycle.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      iv = ($urandom % 4) != 0;
      case ($urandom % 4)
        0:       d = int'($urandom_range(4194303)) - 2097152;
        1:       d = (int'($urandom % 64) - 32) * 8;
        2:       d = int'($urandom % 2) ? 2097151 - int'($urandom % 600000)
                                        : -2097152 + int'($urandom % 600000);
        default: d = int'($urandom_range(65535)) - 32768;
      endcase
      rdy = (n % 200 < 100) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      clr = ($urandom % 40) == 0;
      reset = ($urandom % 400) == 0;
      cyc(iv, d, rdy, clr);
    end
    reset = 1'b0;
    repeat (8) cyc(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
